// File: rtl/iter_divider.sv
// iter_divider: multicycle radix-2 restoring divider with independent operand handshakes
module iter_divider #(
  parameter bit SIGNED = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] s_axis_dividend_tdata,
  input  logic        s_axis_dividend_tvalid,
  output logic        s_axis_dividend_tready,
  input  logic [31:0] s_axis_divisor_tdata,
  input  logic        s_axis_divisor_tvalid,
  output logic        s_axis_divisor_tready,
  output logic [63:0] m_axis_dout_tdata,
  output logic        m_axis_dout_tvalid
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t      state_q, state_d;
  logic        got_a_q, got_a_d, got_b_q, got_b_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [32:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d, dvs_q, dvs_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        nq_q, nq_d, nr_q, nr_d;
  logic [63:0] dout_q, dout_d;
  logic        a_hs, b_hs, start, a_neg, b_neg, ge;
  logic [31:0] a_v, b_v, a_m, b_m, q_nx, r_lo;
  logic [32:0] shl, r_nx;
  logic [33:0] diff;
  // ready is forced low while reset is held so nothing is accepted in the reset cycle
  assign s_axis_dividend_tready = (state_q == IDLE) && !got_a_q && !reset;
  assign s_axis_divisor_tready  = (state_q == IDLE) && !got_b_q && !reset;
  assign m_axis_dout_tvalid     = (state_q == DONE);
  assign m_axis_dout_tdata      = dout_q;
  assign a_hs  = s_axis_dividend_tvalid && s_axis_dividend_tready;
  assign b_hs  = s_axis_divisor_tvalid && s_axis_divisor_tready;
  assign a_v   = a_hs ? s_axis_dividend_tdata : a_q;
  assign b_v   = b_hs ? s_axis_divisor_tdata : b_q;
  assign start = (state_q == IDLE) && (got_a_q || a_hs) && (got_b_q || b_hs);
  assign a_neg = SIGNED && a_v[31];
  assign b_neg = SIGNED && b_v[31];
  assign a_m   = a_neg ? -a_v : a_v;
  assign b_m   = b_neg ? -b_v : b_v;
  // one restoring step: shift in next dividend bit, keep the subtraction only if non-negative
  assign shl   = {rem_q[31:0], quo_q[31]};
  assign diff  = {1'b0, shl} - {2'b0, dvs_q};
  assign ge    = !diff[33];
  assign r_nx  = ge ? diff[32:0] : shl;
  assign q_nx  = {quo_q[30:0], ge};
  assign r_lo  = r_nx[31:0];
  // next-state, operand capture, iteration and result formatting
  always_comb begin
    state_d = state_q;
    got_a_d = got_a_q;
    got_b_d = got_b_q;
    a_d     = a_q;
    b_d     = b_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    nq_d    = nq_q;
    nr_d    = nr_q;
    dout_d  = dout_q;
    case (state_q)
      IDLE: begin
        got_a_d = got_a_q || a_hs;
        got_b_d = got_b_q || b_hs;
        a_d     = a_v;
        b_d     = b_v;
        if (start) begin
          state_d = CALC;
          cnt_d   = '0;
          rem_d   = '0;
          quo_d   = a_m;
          dvs_d   = b_m;
          nq_d    = a_neg ^ b_neg;
          nr_d    = a_neg;
        end
      end
      CALC: begin
        rem_d = r_nx;
        quo_d = q_nx;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = DONE;
          dout_d  = {nq_q ? -q_nx : q_nx, nr_q ? -r_lo : r_lo};
        end
      end
      default: begin
        state_d = IDLE;
        got_a_d = 1'b0;
        got_b_d = 1'b0;
      end
    endcase
  end
  // state and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      got_a_q <= 1'b0;
      got_b_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      nq_q    <= 1'b0;
      nr_q    <= 1'b0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      got_a_q <= got_a_d;
      got_b_q <= got_b_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      nq_q    <= nq_d;
      nr_q    <= nr_d;
      dout_q  <= dout_d;
    end
  end
endmodule

// File: tb/tb_iter_divider.sv
// tb_iter_divider: randomized and directed checks of signed and unsigned dividers against an arithmetic model
module tb_iter_divider;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] dvd_data = '0, dvs_data = '0;
  logic        dvd_valid = 1'b0, dvs_valid = 1'b0;
  logic        rdy_a_u, rdy_b_u, vld_u, rdy_a_s, rdy_b_s, vld_s;
  logic [63:0] dout_u, dout_s;
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_err = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  iter_divider #(.SIGNED(1'b0)) u_u (
    .clk(clk), .reset(reset),
    .s_axis_dividend_tdata(dvd_data), .s_axis_dividend_tvalid(dvd_valid), .s_axis_dividend_tready(rdy_a_u),
    .s_axis_divisor_tdata(dvs_data), .s_axis_divisor_tvalid(dvs_valid), .s_axis_divisor_tready(rdy_b_u),
    .m_axis_dout_tdata(dout_u), .m_axis_dout_tvalid(vld_u)
  );
  iter_divider #(.SIGNED(1'b1)) u_s (
    .clk(clk), .reset(reset),
    .s_axis_dividend_tdata(dvd_data), .s_axis_dividend_tvalid(dvd_valid), .s_axis_dividend_tready(rdy_a_s),
    .s_axis_divisor_tdata(dvs_data), .s_axis_divisor_tvalid(dvs_valid), .s_axis_divisor_tready(rdy_b_s),
    .m_axis_dout_tdata(dout_s), .m_axis_dout_tvalid(vld_s)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input bit sg);
    longint ma, mb, qm, rm;
    bit sa, sb;
    logic [31:0] q, r;
    sa = sg && a[31];
    sb = sg && b[31];
    ma = longint'(a);
    mb = longint'(b);
    if (sa) ma = 64'h1_0000_0000 - ma;
    if (sb) mb = 64'h1_0000_0000 - mb;
    qm = (mb == 0) ? 64'hFFFF_FFFF : ma / mb;
    rm = (mb == 0) ? ma : ma % mb;
    q = (sa ^ sb) ? 32'(-qm) : 32'(qm);
    r = sa ? 32'(-rm) : 32'(rm);
    return {q, r};
  endfunction
  task automatic run(input logic [31:0] a, input logic [31:0] b, input int d, output logic [63:0] ru, output logic [63:0] rs);
    int n, e_a, e_b, t;
    bit ga, gb, ha, hb, busy_ok;
    dvd_data = a;
    dvs_data = b;
    dvd_valid = 1'b1;
    dvs_valid = (d == 0);
    ga = 0; gb = 0; n = 0; e_a = 0; e_b = 0;
    while (!(ga && gb) && n < 50) begin
      ha = dvd_valid && rdy_a_u;
      hb = dvs_valid && rdy_b_u;
      @(posedge clk); #1;
      n++;
      if (ha) begin ga = 1; dvd_valid = 1'b0; e_a = cyc; end
      if (hb) begin gb = 1; dvs_valid = 1'b0; e_b = cyc; end
      if (ga && !gb) chk("dvd_rdy_low", {rdy_a_u, rdy_a_s}, 2'b00);
      if (n == d) dvs_valid = 1'b1;
    end
    chk("accept", {ga, gb}, 2'b11);
    if (d > 0) chk("stagger", e_b - e_a, d);
    t = 0;
    busy_ok = 1;
    while (!vld_u && t < 40) begin
      busy_ok &= !rdy_a_u && !rdy_b_u && !rdy_a_s && !rdy_b_s;
      @(posedge clk); #1;
      t++;
    end
    busy_ok &= !rdy_a_u && !rdy_b_u && !rdy_a_s && !rdy_b_s;
    chk("latency", t, 32);
    chk("busy", busy_ok, 1);
    chk("vld_s", vld_s, 1);
    ru = dout_u;
    rs = dout_s;
    chk("res_u", dout_u, model(a, b, 0));
    chk("res_s", dout_s, model(a, b, 1));
    @(posedge clk); #1;
    chk("pulse_end", {vld_u, vld_s}, 2'b00);
    chk("rdy_back", {rdy_a_u, rdy_b_u, rdy_a_s, rdy_b_s}, 4'hF);
    chk("hold", {dout_u ^ ru, dout_s ^ rs}, '0);
  endtask
  initial begin
    logic [63:0] ru, rs;
    logic [63:0] qu[$], qs[$];
    logic [31:0] a, b;
    int pulses, last, k;
    bit hs;
    @(posedge clk); #1;
    chk("rst_rdy", {rdy_a_u, rdy_b_u, rdy_a_s, rdy_b_s}, 4'h0);
    chk("rst_vld", {vld_u, vld_s}, 2'b00);
    chk("rst_data", dout_u | dout_s, 64'h0);
    reset = 1'b0;
    #1;
    chk("idle_rdy", {rdy_a_u, rdy_b_u, rdy_a_s, rdy_b_s}, 4'hF);
    run(32'd100, 32'd7, 0, ru, rs);
    chk("100/7", ru, 64'h0000000E_00000002);
    run(32'hFFFF_FFF9, 32'd2, 0, ru, rs);
    chk("-7/2", rs, 64'hFFFFFFFD_FFFFFFFF);
    run(32'd7, 32'hFFFF_FFFE, 0, ru, rs);
    chk("7/-2", rs, 64'hFFFFFFFD_00000001);
    run(32'h8000_0000, 32'hFFFF_FFFF, 0, ru, rs);
    chk("ovf", rs, 64'h80000000_00000000);
    run(32'd5, 32'd0, 0, ru, rs);
    chk("5/0", ru, 64'hFFFFFFFF_00000005);
    run(32'hFFFF_FFFB, 32'd0, 0, ru, rs);
    chk("-5/0", rs, 64'h00000001_FFFFFFFB);
    run(32'd1234, 32'd56, 3, ru, rs);
    dvd_data = 32'd100; dvs_data = 32'd7;
    dvd_valid = 1'b1; dvs_valid = 1'b1;
    @(posedge clk); #1;
    dvd_valid = 1'b0; dvs_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    chk("mid_rst_rdy", {rdy_a_u, rdy_b_u, rdy_a_s, rdy_b_s}, 4'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("post_rst_rdy", {rdy_a_u, rdy_b_u, rdy_a_s, rdy_b_s}, 4'hF);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      if (vld_u || vld_s) pulses++;
      @(posedge clk); #1;
    end
    chk("no_pulse", pulses, 0);
    run(32'd9, 32'd3, 0, ru, rs);
    chk("9/3", ru, 64'h00000003_00000000);
    for (int i = 0; i < 10; i++) begin
      k = $urandom_range(0, 5);
      a = (k == 0) ? 32'h8000_0000 : $urandom;
      b = (k == 1) ? 32'd0 : (k == 2) ? 32'hFFFF_FFFF : (k == 3) ? 32'($urandom_range(1, 300)) : $urandom;
      run(a, b, $urandom_range(0, 3), ru, rs);
    end
    a = $urandom; b = $urandom_range(1, 1000);
    dvd_data = a; dvs_data = b;
    dvd_valid = 1'b1; dvs_valid = 1'b1;
    pulses = 0; last = -1;
    for (int i = 0; i < 200 && pulses < 4; i++) begin
      hs = rdy_a_u && rdy_b_u;
      @(posedge clk); #1;
      if (hs) begin
        qu.push_back(model(a, b, 0));
        qs.push_back(model(a, b, 1));
        a = $urandom; b = $urandom;
        dvd_data = a; dvs_data = b;
      end
      if (vld_u) begin
        if (qu.size() > 0) begin
          chk("b2b_u", dout_u, qu.pop_front());
          chk("b2b_s", dout_s, qs.pop_front());
        end else chk("b2b_unexpected", 1, 0);
        if (last >= 0) chk("period", cyc - last, 34);
        last = cyc;
        pulses++;
      end
    end
    chk("b2b_count", pulses, 4);
    dvd_valid = 1'b0; dvs_valid = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/iter_divider.md
Name: iter_divider

Overview:
Multicycle radix-2 restoring divider that serves as the responder for the execute stage's divide handshake. It accepts dividend and divisor on two independent valid/ready channels. It returns {quotient, remainder} on a valid-only output channel with a fixed latency of 32 cycles. Two instances (SIGNED=1 for div, SIGNED=0 for divu) sit beside the ALU in the execute stage.

Parameters:
SIGNED, 1, 1 = two's-complement operands and results; 0 = unsigned.

Ports:
clk  input  1  clock, rising edge.
reset  input  1  synchronous active-high reset.
s_axis_dividend_tdata  input  32  dividend.
s_axis_dividend_tvalid  input  1  dividend valid.
s_axis_dividend_tready  output  1  dividend may be accepted.
s_axis_divisor_tdata  input  32  divisor.
s_axis_divisor_tvalid  input  1  divisor valid.
s_axis_divisor_tready  output  1  divisor may be accepted.
m_axis_dout_tdata  output  64  {quotient[63:32], remainder[31:0]}.
m_axis_dout_tvalid  output  1  one-cycle result pulse; no backpressure.

Behaviour:
- Interface fact: one clock (clk); reset is synchronous and active-high (reset).
- Reset values: both tready outputs 0 in the reset cycle, then 1 in IDLE. m_axis_dout_tvalid = 0. m_axis_dout_tdata = 0.
- A handshake occurs on an edge where tvalid and tready are both 1. tdata is captured at that edge.
- Each channel has a "got" flag. A channel's tready = (state == IDLE) && !got. The channels are independent, in any order, and may complete in the same cycle.
- States:
  - IDLE → CALC on the edge where the second operand is captured (the second of two, or both at once).
  - CALC: 32 iteration cycles. Counter runs 0..31. At count 31, → DONE.
  - DONE: one cycle. m_axis_dout_tvalid = 1. Then → IDLE, and both got flags clear.
- Latency: with the last operand captured at edge E, iterations occur at edges E+1..E+32. tdata is registered at edge E+32. tvalid is high from edge E+32 to edge E+33 only. tready is 0 from edge E until edge E+33, then 1.
- m_axis_dout_tdata holds its value after the pulse until the next result is written.
- Arithmetic:
  - SIGNED=1: operate on the magnitudes |dividend| and |divisor| (33-bit internal so that 0x80000000 is safe).
  - Quotient is negated when the dividend sign differs from the divisor sign. Remainder takes the dividend's sign.
  - Each iteration shifts the partial remainder left, subtracts the divisor, and restores when the result is negative. The quotient bit is 1 when no restore is needed.
- Divide by zero: no exception and no hang. Quotient magnitude = 0xFFFFFFFF and remainder magnitude = |dividend| (the natural restoring result), then sign correction applies.
- Overflow case -2^31 / -1 (signed): quotient = 0x80000000, remainder = 0.
- Reset mid-operation (any state): the result is discarded and no tvalid pulse follows. Return to IDLE, clear got flags, tready = 1 from the cycle after reset deasserts.
- tvalid asserted while tready = 0 has no effect. The requester holds tvalid until its handshake completes.
- Only one operation may be in flight; there is no pipelining.

Test Plan:
- SIGNED=0, dividend 100 and divisor 7 in the same cycle (edge E) → tvalid only in the cycle after edge E+32, tdata = 0x0000000E_00000002; both treadys 0 during edges E..E+32.
- SIGNED=1, -7 / 2 → tdata = 0xFFFFFFFD_FFFFFFFF. 7 / -2 → 0xFFFFFFFD_00000001.
- SIGNED=1, 0x80000000 / 0xFFFFFFFF → 0x80000000_00000000. SIGNED=0, 5 / 0 → 0xFFFFFFFF_00000005. SIGNED=1, -5 / 0 → 0x00000001_FFFFFFFB.
- Staggered operands: dividend handshake at edge 0, divisor tvalid raised at edge 3:
  - dividend_tready = 0 from edge 0 onward;
  - divisor accepted at edge 3;
  - tvalid pulse after edge 35.
- Reset asserted at the 10th CALC cycle for one cycle → no tvalid ever appears. Both treadys are 1 the cycle after reset. A fresh 9 / 3 then yields 0x00000003_00000000 after 32 cycles.
- Back-to-back: hold tvalid on both channels continuously → a new accept occurs one cycle after each pulse. Sustained period = 34 cycles per result, with every result correct.
